gray_bin_seq_ctrl: RTL



---
 rtl/gray_bin_seq_ctrl_pkg.sv | 15 +
 rtl/gray_bin_seq_ctrl_if.sv | 36 +++
 rtl/gray_bin_seq_ctrl_xor_cell.sv | 27 ++
 rtl/gray_bin_seq_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/gray_bin_seq_ctrl_pkg.sv
// Shared types and constants for the bit-serial Gray/binary converter.
// Holds the FSM encoding, the mode encoding and the width limit.
package gray_bin_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_G2B  = 1'b0;
  localparam logic MODE_B2G  = 1'b1;
  localparam int   MAX_WIDTH = 32;

endpackage

// File: rtl/gray_bin_seq_ctrl_if.sv
// Handshake bundle between the code source, the converter and the binary consumer.
// The mode signal exists only when GB_B2G_MODE_EN is defined.
interface gray_bin_seq_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] g_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] b_out;
  logic             busy;
`ifdef GB_B2G_MODE_EN
  logic             mode;

  modport master (
    output in_valid, g_in, out_ready, mode,
    input  in_ready, out_valid, b_out, busy
  );

  modport slave (
    input  in_valid, g_in, out_ready, mode,
    output in_ready, out_valid, b_out, busy
  );
`else
  modport master (
    output in_valid, g_in, out_ready,
    input  in_ready, out_valid, b_out, busy
  );

  modport slave (
    input  in_valid, g_in, out_ready,
    output in_ready, out_valid, b_out, busy
  );
`endif
endinterface

// File: rtl/gray_bin_seq_ctrl_xor_cell.sv
// Single conversion cell: y = a XOR b built from two 1:2 demuxes and an OR.
// Purely combinational; the controller steers operands into it one bit per cycle.
module gray_xor_demux (
  input  logic       d,
  input  logic       sel,
  output logic [1:0] y
);
  assign y[0] = d & ~sel;
  assign y[1] = d &  sel;
endmodule

module gray_xor_cell (
  input  logic a,
  input  logic b,
  output logic y
);
  logic [1:0] a_by_b;
  logic [1:0] b_by_a;
  logic       unused_and;

  gray_xor_demux u_dmx_a (.d(a), .sel(b), .y(a_by_b));
  gray_xor_demux u_dmx_b (.d(b), .sel(a), .y(b_by_a));

  // a&~b | b&~a; the select-high legs are not needed for XOR.
  assign y          = a_by_b[0] | b_by_a[0];
  assign unused_and = a_by_b[1] & b_by_a[1];
endmodule

// File: rtl/gray_bin_seq_ctrl.sv
// Bit-serial Gray->binary controller (binary->Gray too with GB_B2G_MODE_EN); out_valid WIDTH-1 edges after accept.
// Holds result in DONE while out_ready is low; in_ready is low outside IDLE, so accept and deliver never overlap.
module gray_bin_seq_ctrl
  import gray_bin_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  gray_bin_seq_ctrl_if.slave bus
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_chk
    $error("gray_bin_seq_ctrl: WIDTH out of range");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] hi_idx;
  logic [WIDTH-1:0] g_q, g_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             in_ready_q, in_ready_d;
  logic             mode_q;
  logic             accept;
  logic             cell_a, cell_b, cell_y;

`ifdef GB_B2G_MODE_EN
  logic mode_d;
`else
  assign mode_q = MODE_G2B;
`endif

  assign accept = bus.in_valid && in_ready_q;
  assign hi_idx = idx_q + IDX_W'(1);

  // Only the registered word feeds the cell; the live input bus never does.
  always_comb begin
    cell_b = g_q[idx_q];
    cell_a = b_q[hi_idx];
    if (mode_q == MODE_B2G) begin
      cell_a = g_q[hi_idx];
    end
  end

  gray_xor_cell u_cell (
    .a (cell_a),
    .b (cell_b),
    .y (cell_y)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    g_d     = g_q;
    b_d     = b_q;
`ifdef GB_B2G_MODE_EN
    mode_d  = mode_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          g_d            = bus.g_in;
          b_d            = '0;
          b_d[WIDTH-1]   = bus.g_in[WIDTH-1];
`ifdef GB_B2G_MODE_EN
          mode_d         = bus.mode;
`endif
          if (WIDTH > 1) begin
            idx_d   = IDX_W'(WIDTH - 2);
            state_d = CONV;
          end else begin
            state_d = DONE;
          end
        end
      end
      CONV: begin
        b_d[idx_q] = cell_y;
        if (idx_q == '0) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Registered so that in_ready stays low while reset is asserted.
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      g_q        <= '0;
      b_q        <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      g_q        <= g_d;
      b_q        <= b_d;
      in_ready_q <= in_ready_d;
    end
  end

`ifdef GB_B2G_MODE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_G2B;
    end else begin
      mode_q <= mode_d;
    end
  end
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q == DONE);
  assign bus.b_out     = b_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
